regfile_sequencer: RTL and testbench

REGFILE_SEQUENCER -- requirements
Module: regfile_sequencer

---
 rtl/regfile_sequencer_pkg.sv | 59 +++++
 rtl/regfile_sequencer_if.sv | 43 ++++
 rtl/regfile_sequencer_regsel_decode.sv | 25 ++
 rtl/regfile_sequencer.sv | 160 ++++++++++++++++
 tb/tb_regfile_sequencer.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// regfile_sequencer_pkg
// Shared definitions for the register-file sequencer:
//   - FunSel codes understood by the register file (FS_*)
//   - command opcodes (OP_*)
//   - FSM state type and state constants (ST_*)
//   - SCR_IDX, the scratch register S4 that SWAP uses as a temporary
//   - small helpers that classify a command by opcode/source/destination
// No ports; imported by the interface users and the sub-module.
// ---------------------------------------------------------------------------
package regfile_sequencer_pkg;

   localparam logic [2:0] FS_DEC  = 3'b000;
   localparam logic [2:0] FS_INC  = 3'b001;
   localparam logic [2:0] FS_LOAD = 3'b010;
   localparam logic [2:0] FS_CLR  = 3'b011;

   localparam logic [2:0] OP_NOP     = 3'b000;
   localparam logic [2:0] OP_LOAD    = 3'b001;
   localparam logic [2:0] OP_CLEAR   = 3'b010;
   localparam logic [2:0] OP_INC     = 3'b011;
   localparam logic [2:0] OP_DEC     = 3'b100;
   localparam logic [2:0] OP_MOVE    = 3'b101;
   localparam logic [2:0] OP_SWAP    = 3'b110;
   localparam logic [2:0] OP_ILLEGAL = 3'b111;

   // S4 is the swap temporary, so a SWAP touching it would corrupt itself
   localparam logic [2:0] SCR_IDX = 3'd7;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE = 3'd0;
   localparam state_t ST_EXEC = 3'd1;
   localparam state_t ST_SW1  = 3'd2;
   localparam state_t ST_SW2  = 3'd3;
   localparam state_t ST_SW3  = 3'd4;

   // Ops that write exactly one register in the single EXEC cycle
   function automatic logic is_write_op(input logic [2:0] op);
      return (op == OP_LOAD) || (op == OP_CLEAR) || (op == OP_INC) ||
             (op == OP_DEC)  || (op == OP_MOVE);
   endfunction

   // Commands answered with err instead of done
   function automatic logic is_rejected(input logic [2:0] op,
                                        input logic [2:0] src,
                                        input logic [2:0] dst);
      return (op == OP_ILLEGAL) ||
             ((op == OP_SWAP) && ((src == SCR_IDX) || (dst == SCR_IDX)));
   endfunction

   // A SWAP that really moves data; src==dst degenerates to a NOP
   function automatic logic is_real_swap(input logic [2:0] op,
                                         input logic [2:0] src,
                                         input logic [2:0] dst);
      return (op == OP_SWAP) && !is_rejected(op, src, dst) && (src != dst);
   endfunction

endpackage

// File: rtl/regfile_sequencer_if.sv
// ---------------------------------------------------------------------------
// regfile_sequencer_if
// Bundles the command handshake and the register-file control bus.
//   command side : cmd_valid, cmd_ready, cmd_op, cmd_dst, cmd_src, cmd_data
//   read port    : rd_sel (forwarded to OutBSel)
//   regfile side : rf_OutA (data in), FunSel, RegSel, ScrSel, OutASel,
//                  OutBSel, rf_I (controls out)
//   status       : done, err
// slave  : the sequencer
// master : the environment (command source plus register file)
// ---------------------------------------------------------------------------
interface regfile_sequencer_if #(parameter int DATA_W = 32);

   logic              cmd_valid;
   logic              cmd_ready;
   logic [2:0]        cmd_op;
   logic [2:0]        cmd_dst;
   logic [2:0]        cmd_src;
   logic [DATA_W-1:0] cmd_data;
   logic [2:0]        rd_sel;
   logic [DATA_W-1:0] rf_OutA;
   logic [2:0]        FunSel;
   logic [3:0]        RegSel;
   logic [3:0]        ScrSel;
   logic [2:0]        OutASel;
   logic [2:0]        OutBSel;
   logic [DATA_W-1:0] rf_I;
   logic              done;
   logic              err;

   modport slave (
      input  cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_data, rd_sel, rf_OutA,
      output cmd_ready, FunSel, RegSel, ScrSel, OutASel, OutBSel, rf_I,
             done, err
   );

   modport master (
      output cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_data, rd_sel, rf_OutA,
      input  cmd_ready, FunSel, RegSel, ScrSel, OutASel, OutBSel, rf_I,
             done, err
   );

endinterface

// File: rtl/regfile_sequencer_regsel_decode.sv
// ---------------------------------------------------------------------------
// regsel_decode
// Turns a 3-bit register index plus a write strobe into the one-hot
// write-enable vector {ScrSel, RegSel}.
//   i_idx : 0-3 -> R1-R4 (RegSel[0..3]), 4-7 -> S1-S4 (ScrSel[0..3])
//   i_we  : write strobe; when low every enable is low
//   o_sel : {ScrSel, RegSel}
// ---------------------------------------------------------------------------
module regsel_decode
   import regfile_sequencer_pkg::*;
(
   input  logic [2:0] i_idx,
   input  logic       i_we,
   output logic [7:0] o_sel
);

   // The index maps straight onto bit position of {ScrSel, RegSel}
   always_comb begin
      o_sel = 8'b0;
      if (i_we) begin
         o_sel = 8'b1 << i_idx;
      end
   end

endmodule

// File: rtl/regfile_sequencer.sv
// ---------------------------------------------------------------------------
// regfile_sequencer
// Accepts one command at a time and drives the register-file controls to
// execute it: single-cycle LOAD/CLEAR/INC/DEC/MOVE, a three-step SWAP through
// scratch register S4, and err for rejected commands.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : regfile_sequencer_if.slave (command handshake + regfile bus)
// Every control output is decoded from the registered state and latched
// command fields, so cmd_* never reaches the register file combinationally.
// ---------------------------------------------------------------------------
module regfile_sequencer
   import regfile_sequencer_pkg::*;
#(
   parameter int DATA_W = 32
)
(
   input  logic               clk,
   input  logic               rst_n,
   regfile_sequencer_if.slave bus
);

   state_t            r_state;
   state_t            w_next_state;
   logic [2:0]        r_op;
   logic [2:0]        r_dst;
   logic [2:0]        r_src;
   logic [DATA_W-1:0] r_data;

   logic              w_accept;
   logic              w_we;
   logic [2:0]        w_idx;
   logic [7:0]        w_sel;
   logic [2:0]        w_funsel;
   logic [2:0]        w_outasel;
   logic [DATA_W-1:0] w_rf_i;
   logic              w_done;
   logic              w_err;

   assign w_accept = (r_state == ST_IDLE) && bus.cmd_valid;

   // Next-state logic; only IDLE looks at the incoming command
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (bus.cmd_valid) begin
               w_next_state = is_real_swap(bus.cmd_op, bus.cmd_src, bus.cmd_dst)
                              ? ST_SW1 : ST_EXEC;
            end
         end
         ST_EXEC: w_next_state = ST_IDLE;
         ST_SW1:  w_next_state = ST_SW2;
         ST_SW2:  w_next_state = ST_SW3;
         ST_SW3:  w_next_state = ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   // State register; reset aborts a SWAP wherever it is
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Command fields are captured only on an accepted handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op   <= OP_NOP;
         r_dst  <= 3'd0;
         r_src  <= 3'd0;
         r_data <= '0;
      end else if (w_accept) begin
         r_op   <= bus.cmd_op;
         r_dst  <= bus.cmd_dst;
         r_src  <= bus.cmd_src;
         r_data <= bus.cmd_data;
      end
   end

   // Output decode. SWAP steps: S4<=dst, dst<=src, src<=S4, each a LOAD of
   // port A, so OutASel picks the source of the step and rf_I echoes it.
   always_comb begin
      w_we      = 1'b0;
      w_idx     = 3'd0;
      w_funsel  = FS_LOAD;
      w_outasel = 3'd0;
      w_rf_i    = '0;
      w_done    = 1'b0;
      w_err     = 1'b0;
      case (r_state)
         ST_EXEC: begin
            if (is_rejected(r_op, r_src, r_dst)) begin
               w_err = 1'b1;
            end else begin
               w_done = 1'b1;
            end
            if (is_write_op(r_op)) begin
               w_we  = 1'b1;
               w_idx = r_dst;
               case (r_op)
                  OP_CLEAR: w_funsel = FS_CLR;
                  OP_INC:   w_funsel = FS_INC;
                  OP_DEC:   w_funsel = FS_DEC;
                  default:  w_funsel = FS_LOAD;
               endcase
               if (r_op == OP_LOAD) begin
                  w_rf_i = r_data;
               end
               if (r_op == OP_MOVE) begin
                  w_outasel = r_src;
                  w_rf_i    = bus.rf_OutA;
               end
            end
         end
         ST_SW1: begin
            w_we      = 1'b1;
            w_idx     = SCR_IDX;
            w_outasel = r_dst;
            w_rf_i    = bus.rf_OutA;
         end
         ST_SW2: begin
            w_we      = 1'b1;
            w_idx     = r_dst;
            w_outasel = r_src;
            w_rf_i    = bus.rf_OutA;
         end
         ST_SW3: begin
            w_we      = 1'b1;
            w_idx     = r_src;
            w_outasel = SCR_IDX;
            w_rf_i    = bus.rf_OutA;
            w_done    = 1'b1;
         end
         default: begin
            w_we = 1'b0;
         end
      endcase
   end

   regsel_decode u_regsel_decode (
      .i_idx (w_idx),
      .i_we  (w_we),
      .o_sel (w_sel)
   );

   assign bus.cmd_ready = (r_state == ST_IDLE);
   assign bus.RegSel    = w_sel[3:0];
   assign bus.ScrSel    = w_sel[7:4];
   assign bus.FunSel    = w_funsel;
   assign bus.OutASel   = w_outasel;
   assign bus.OutBSel   = bus.rd_sel;
   assign bus.rf_I      = w_rf_i;
   assign bus.done      = w_done;
   assign bus.err       = w_err;

endmodule

// File: tb/tb_regfile_sequencer.sv
// ---------------------------------------------------------------------------
// tb_regfile_sequencer
// Drives regfile_sequencer through a table of single commands and a few
// hand-written multi-cycle sequences (SWAP, held cmd_valid, reset mid-SWAP).
// A small behavioural register file sits on the bus so that results can be
// read back through rd_sel / OutBSel.
// ---------------------------------------------------------------------------
module tb_regfile_sequencer;
   import regfile_sequencer_pkg::*;

   logic clk;
   logic rst_n;
   logic rfInit;

   int checks;
   int errors;

   regfile_sequencer_if #(.DATA_W(32)) bus ();

   regfile_sequencer #(.DATA_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural register file: R1-R4 at 0-3, S1-S4 at 4-7
   logic [31:0] rf [8];
   logic [7:0]  wSel;
   logic [31:0] outB;

   assign wSel        = {bus.ScrSel, bus.RegSel};
   assign bus.rf_OutA = rf[bus.OutASel];
   assign outB        = rf[bus.OutBSel];

   // Register file write port, cleared once at the start of the run
   always @(posedge clk) begin
      for (int k = 0; k < 8; k++) begin
         if (rfInit) begin
            rf[k] <= 32'h0;
         end else if (wSel[k]) begin
            case (bus.FunSel)
               3'b010:  rf[k] <= bus.rf_I;
               3'b011:  rf[k] <= 32'h0;
               3'b001:  rf[k] <= rf[k] + 32'd1;
               3'b000:  rf[k] <= rf[k] - 32'd1;
               default: rf[k] <= rf[k];
            endcase
         end
      end
   end

   // Safety net so the run always terminates
   initial begin
      #100000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // One comparison with a failure line on mismatch
   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Presents a command on the bus
   task automatic applyStimulus(input logic valid, input logic [2:0] op,
                                input logic [2:0] dst, input logic [2:0] src,
                                input logic [31:0] data);
      bus.cmd_valid = valid;
      bus.cmd_op    = op;
      bus.cmd_dst   = dst;
      bus.cmd_src   = src;
      bus.cmd_data  = data;
   endtask

   typedef struct {
      logic [2:0]  op;
      logic [2:0]  dst;
      logic [2:0]  src;
      logic [31:0] data;
      logic [2:0]  rdSel;
      logic [3:0]  expReg;
      logic [3:0]  expScr;
      logic [2:0]  expFun;
      logic [2:0]  expOutA;
      logic [31:0] expRfI;
      logic        expDone;
      logic        expErr;
      logic [31:0] expOutB;
   } vec_t;

   vec_t vecs [15];

   // Single commands: check the EXEC cycle, then read the result back
   initial begin
      checks = 0;
      errors = 0;
      rfInit = 1'b1;
      rst_n  = 1'b0;
      bus.rd_sel = 3'd5;
      applyStimulus(1'b1, OP_LOAD, 3'd1, 3'd0, 32'h12345678);

      vecs[0]  = '{OP_LOAD,  3'd2, 3'd0, 32'hDEADBEEF, 3'd2, 4'b0100, 4'b0000, 3'b010, 3'd0, 32'hDEADBEEF, 1'b1, 1'b0, 32'hDEADBEEF};
      vecs[1]  = '{OP_CLEAR, 3'd5, 3'd0, 32'h00000123, 3'd5, 4'b0000, 4'b0010, 3'b011, 3'd0, 32'h0, 1'b1, 1'b0, 32'h0};
      vecs[2]  = '{OP_INC,   3'd5, 3'd0, 32'h0, 3'd5, 4'b0000, 4'b0010, 3'b001, 3'd0, 32'h0, 1'b1, 1'b0, 32'h1};
      vecs[3]  = '{OP_INC,   3'd5, 3'd0, 32'h0, 3'd5, 4'b0000, 4'b0010, 3'b001, 3'd0, 32'h0, 1'b1, 1'b0, 32'h2};
      vecs[4]  = '{OP_INC,   3'd5, 3'd0, 32'h0, 3'd5, 4'b0000, 4'b0010, 3'b001, 3'd0, 32'h0, 1'b1, 1'b0, 32'h3};
      vecs[5]  = '{OP_LOAD,  3'd0, 3'd0, 32'h11, 3'd0, 4'b0001, 4'b0000, 3'b010, 3'd0, 32'h11, 1'b1, 1'b0, 32'h11};
      vecs[6]  = '{OP_LOAD,  3'd3, 3'd0, 32'h44, 3'd3, 4'b1000, 4'b0000, 3'b010, 3'd0, 32'h44, 1'b1, 1'b0, 32'h44};
      vecs[7]  = '{OP_DEC,   3'd5, 3'd0, 32'h0, 3'd5, 4'b0000, 4'b0010, 3'b000, 3'd0, 32'h0, 1'b1, 1'b0, 32'h2};
      vecs[8]  = '{OP_MOVE,  3'd6, 3'd2, 32'h0, 3'd6, 4'b0000, 4'b0100, 3'b010, 3'd2, 32'hDEADBEEF, 1'b1, 1'b0, 32'hDEADBEEF};
      vecs[9]  = '{OP_MOVE,  3'd6, 3'd6, 32'h0, 3'd6, 4'b0000, 4'b0100, 3'b010, 3'd6, 32'hDEADBEEF, 1'b1, 1'b0, 32'hDEADBEEF};
      vecs[10] = '{OP_NOP,   3'd2, 3'd1, 32'hFFFF, 3'd2, 4'b0000, 4'b0000, 3'b010, 3'd0, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF};
      vecs[11] = '{OP_ILLEGAL, 3'd2, 3'd0, 32'hFFFF, 3'd2, 4'b0000, 4'b0000, 3'b010, 3'd0, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF};
      vecs[12] = '{OP_SWAP,  3'd7, 3'd0, 32'h0, 3'd0, 4'b0000, 4'b0000, 3'b010, 3'd0, 32'h0, 1'b0, 1'b1, 32'h11};
      vecs[13] = '{OP_SWAP,  3'd0, 3'd0, 32'h0, 3'd0, 4'b0000, 4'b0000, 3'b010, 3'd0, 32'h0, 1'b1, 1'b0, 32'h11};
      vecs[14] = '{OP_SWAP,  3'd3, 3'd7, 32'h0, 3'd3, 4'b0000, 4'b0000, 3'b010, 3'd0, 32'h0, 1'b0, 1'b1, 32'h44};

      // Reset state, with a command already presented
      @(negedge clk);
      checkOutput("rst_ready",   32'(bus.cmd_ready), 32'h1);
      checkOutput("rst_RegSel",  32'(bus.RegSel),    32'h0);
      checkOutput("rst_ScrSel",  32'(bus.ScrSel),    32'h0);
      checkOutput("rst_FunSel",  32'(bus.FunSel),    32'h2);
      checkOutput("rst_done",    32'(bus.done),      32'h0);
      checkOutput("rst_err",     32'(bus.err),       32'h0);
      checkOutput("rst_OutBSel", 32'(bus.OutBSel),   32'h5);
      applyStimulus(1'b0, OP_NOP, 3'd0, 3'd0, 32'h0);
      rst_n  = 1'b1;
      rfInit = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 15; i++) begin
         applyStimulus(1'b1, vecs[i].op, vecs[i].dst, vecs[i].src, vecs[i].data);
         bus.rd_sel = vecs[i].rdSel;
         #1;
         checkOutput($sformatf("v%0d_readyIdle", i), 32'(bus.cmd_ready), 32'h1);
         @(negedge clk);
         applyStimulus(1'b0, OP_NOP, 3'd0, 3'd0, 32'h0);
         #1;
         checkOutput($sformatf("v%0d_readyBusy", i), 32'(bus.cmd_ready), 32'h0);
         checkOutput($sformatf("v%0d_RegSel", i),  32'(bus.RegSel),  32'(vecs[i].expReg));
         checkOutput($sformatf("v%0d_ScrSel", i),  32'(bus.ScrSel),  32'(vecs[i].expScr));
         checkOutput($sformatf("v%0d_FunSel", i),  32'(bus.FunSel),  32'(vecs[i].expFun));
         checkOutput($sformatf("v%0d_OutASel", i), 32'(bus.OutASel), 32'(vecs[i].expOutA));
         checkOutput($sformatf("v%0d_rfI", i),     bus.rf_I,         vecs[i].expRfI);
         checkOutput($sformatf("v%0d_done", i),    32'(bus.done),    32'(vecs[i].expDone));
         checkOutput($sformatf("v%0d_err", i),     32'(bus.err),     32'(vecs[i].expErr));
         @(negedge clk);
         #1;
         checkOutput($sformatf("v%0d_readBack", i), outB, vecs[i].expOutB);
         checkOutput($sformatf("v%0d_readyBack", i), 32'(bus.cmd_ready), 32'h1);
         checkOutput($sformatf("v%0d_idleSel", i), 32'(wSel), 32'h0);
      end

      // SWAP R1<->R4 while a different command is held on the bus
      applyStimulus(1'b1, OP_SWAP, 3'd3, 3'd0, 32'h0);
      #1;
      checkOutput("sw_readyIdle", 32'(bus.cmd_ready), 32'h1);
      @(negedge clk);
      applyStimulus(1'b1, OP_LOAD, 3'd1, 3'd0, 32'h77);
      #1;
      checkOutput("sw1_ScrSel",  32'(bus.ScrSel),  32'h8);
      checkOutput("sw1_RegSel",  32'(bus.RegSel),  32'h0);
      checkOutput("sw1_OutASel", 32'(bus.OutASel), 32'h3);
      checkOutput("sw1_rfI",     bus.rf_I,         32'h44);
      checkOutput("sw1_FunSel",  32'(bus.FunSel),  32'h2);
      checkOutput("sw1_done",    32'(bus.done),    32'h0);
      checkOutput("sw1_ready",   32'(bus.cmd_ready), 32'h0);
      @(negedge clk);
      #1;
      checkOutput("sw2_RegSel",  32'(bus.RegSel),  32'h8);
      checkOutput("sw2_ScrSel",  32'(bus.ScrSel),  32'h0);
      checkOutput("sw2_OutASel", 32'(bus.OutASel), 32'h0);
      checkOutput("sw2_rfI",     bus.rf_I,         32'h11);
      checkOutput("sw2_done",    32'(bus.done),    32'h0);
      @(negedge clk);
      #1;
      checkOutput("sw3_RegSel",  32'(bus.RegSel),  32'h1);
      checkOutput("sw3_ScrSel",  32'(bus.ScrSel),  32'h0);
      checkOutput("sw3_OutASel", 32'(bus.OutASel), 32'h7);
      checkOutput("sw3_rfI",     bus.rf_I,         32'h44);
      checkOutput("sw3_done",    32'(bus.done),    32'h1);
      @(negedge clk);
      #1;
      checkOutput("swEnd_ready", 32'(bus.cmd_ready), 32'h1);
      checkOutput("swEnd_sel",   32'(wSel), 32'h0);
      bus.rd_sel = 3'd0;
      #1;
      checkOutput("swEnd_R1", outB, 32'h44);
      bus.rd_sel = 3'd3;
      #1;
      checkOutput("swEnd_R4", outB, 32'h11);
      bus.rd_sel = 3'd1;
      #1;
      checkOutput("heldIgnored_R2", outB, 32'h0);
      @(negedge clk);
      applyStimulus(1'b0, OP_NOP, 3'd0, 3'd0, 32'h0);
      #1;
      checkOutput("held_RegSel", 32'(bus.RegSel), 32'h2);
      checkOutput("held_rfI",    bus.rf_I,        32'h77);
      checkOutput("held_done",   32'(bus.done),   32'h1);
      @(negedge clk);
      #1;
      checkOutput("held_R2",    outB, 32'h77);
      checkOutput("held_once",  32'(wSel), 32'h0);
      checkOutput("held_ready", 32'(bus.cmd_ready), 32'h1);

      // Reset pulled in the second SWAP step (R2<->R3)
      applyStimulus(1'b1, OP_SWAP, 3'd2, 3'd1, 32'h0);
      @(negedge clk);
      applyStimulus(1'b0, OP_NOP, 3'd0, 3'd0, 32'h0);
      @(negedge clk);
      #1;
      checkOutput("rstSw_preRegSel", 32'(bus.RegSel), 32'h4);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("rstSw_RegSel", 32'(bus.RegSel), 32'h0);
      checkOutput("rstSw_ScrSel", 32'(bus.ScrSel), 32'h0);
      checkOutput("rstSw_done",   32'(bus.done),   32'h0);
      checkOutput("rstSw_ready",  32'(bus.cmd_ready), 32'h1);
      checkOutput("rstSw_FunSel", 32'(bus.FunSel), 32'h2);
      @(negedge clk);
      rst_n = 1'b1;
      bus.rd_sel = 3'd2;
      #1;
      checkOutput("rstSw_R3kept", outB, 32'hDEADBEEF);
      checkOutput("rstSw_readyAfter", 32'(bus.cmd_ready), 32'h1);
      applyStimulus(1'b1, OP_LOAD, 3'd0, 3'd0, 32'hCAFE0001);
      @(negedge clk);
      applyStimulus(1'b0, OP_NOP, 3'd0, 3'd0, 32'h0);
      #1;
      checkOutput("postRst_RegSel", 32'(bus.RegSel), 32'h1);
      checkOutput("postRst_done",   32'(bus.done),   32'h1);
      @(negedge clk);
      bus.rd_sel = 3'd0;
      #1;
      checkOutput("postRst_R1", outB, 32'hCAFE0001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
